// File: rtl/buzzer_arbiter.sv
// Quiz-buzzer arbiter: four debounced player buttons and a round-robin first-press
// capture, with an arm/ack round handshake and an optional ARMED timeout.
module buzzer_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] lock,
  input  logic       arm,
  input  logic       ack,
  output logic       playerInputFlag,
  output logic [1:0] firstPlayerFlag,
  output logic       timeout,
  output logic [1:0] state
);

  // state    | meaning
  // S_IDLE   | no round; waiting for arm
  // S_ARMED  | round open; first unlocked press wins, timer running
  // S_CAPT   | winner held on the flags until ack
  // S_TMO    | round expired with no press; waiting for ack
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2,
    S_TMO   = 2'd3
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  logic [3:0]    sync1, sync2, deb, deb_q;
  logic [CW-1:0] cnt [4];
  logic [3:0]    press, live;

  // Flip on the D-th consecutive mismatch so press latency is DEBOUNCE_CYCLES+3 edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_q;
  assign live  = press & ~lock;

  state_t        st, st_n;
  logic [1:0]    rr_ptr, rr_n, first_n, win, idx;
  logic          flag_n, to_n, found, expire;
  logic [TW-1:0] tcnt;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && live[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign expire = (TIMEOUT_CYCLES > 0) && (tcnt == T_LAST);

  always_comb begin
    st_n    = st;
    flag_n  = playerInputFlag;
    first_n = firstPlayerFlag;
    to_n    = timeout;
    rr_n    = rr_ptr;
    case (st)
      S_IDLE: begin
        if (arm) st_n = S_ARMED;
      end
      S_ARMED: begin
        if (ack) begin
          st_n = S_IDLE;
        end else if (found) begin
          st_n    = S_CAPT;
          flag_n  = 1'b1;
          first_n = win;
          rr_n    = win + 2'd1;
        end else if (expire) begin
          st_n = S_TMO;
          to_n = 1'b1;
        end
      end
      S_CAPT: begin
        if (ack) begin
          st_n    = S_IDLE;
          flag_n  = 1'b0;
          first_n = '0;
        end
      end
      S_TMO: begin
        if (ack) begin
          st_n = S_IDLE;
          to_n = 1'b0;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st              <= S_IDLE;
      playerInputFlag <= 1'b0;
      firstPlayerFlag <= '0;
      timeout         <= 1'b0;
      rr_ptr          <= '0;
      tcnt            <= '0;
    end else begin
      st              <= st_n;
      playerInputFlag <= flag_n;
      firstPlayerFlag <= first_n;
      timeout         <= to_n;
      rr_ptr          <= rr_n;
      tcnt            <= (st == S_ARMED) ? tcnt + 1'b1 : '0;
    end
  end

  assign state = st;

endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized button must differ from its debounced level before that level flips.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: ARMED-state timeout in clock cycles; 0 disables the timeout.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 btn  input  4  raw asynchronous player buttons, bit i = player i, active-high.
REQ-006 lock  input  4  per-player lockout mask; 1 = player ignored this round.
REQ-007 arm  input  1  single-cycle CPU pulse starting a round.
REQ-008 ack  input  1  single-cycle CPU pulse acknowledging or cancelling a round.
REQ-009 playerInputFlag  output  1  registered; high while a winner is held.
REQ-010 firstPlayerFlag  output  2  registered; binary index of the winning player.
REQ-011 timeout  output  1  registered; high while in TIMEOUT.
REQ-012 state  output  2  current FSM state: IDLE=0, ARMED=1, CAPTURED=2, TIMEOUT=3.

Function
REQ-013 Each btn bit SHALL pass through a 2-flop synchronizer, then a per-bit debounce counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
- Counter increments each cycle the synchronized value differs from the debounced level.
- Counter clears to 0 whenever the values match.
- Debounced level toggles and the counter clears when the count reaches DEBOUNCE_CYCLES.
REQ-014 A press event SHALL be a debounced 0->1 transition, detected against a registered copy of the debounced level; held levels and releases are never events.
REQ-015 In IDLE, press events are ignored; arm moves the FSM to ARMED on the next edge; ack has no effect.
REQ-016 On entry to ARMED, the timeout counter SHALL clear to 0; it increments once per cycle spent in ARMED.
REQ-017 In ARMED, press events from players with lock[i]=1 (lock sampled in the same cycle) are discarded.
REQ-018 In ARMED, if one or more unlocked press events occur, the FSM goes to CAPTURED on that edge, and on the same edge:
- firstPlayerFlag latches the winner;
- playerInputFlag is set to 1.
REQ-019 Tie-break SHALL be round-robin: scan players rr_ptr, rr_ptr+1, ... modulo 4; the first one with an event wins.
- rr_ptr is a 2-bit register, reset 0.
- rr_ptr becomes winner+1 (mod 4) only on capture.
REQ-020 Latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the first edge sampling a stable high btn to the edge at which playerInputFlag goes high.
REQ-021 In ARMED with TIMEOUT_CYCLES>0, the FSM goes to TIMEOUT with timeout=1 on the TIMEOUT_CYCLES-th edge after entry, if no capture has occurred.
REQ-022 A press event and timeout expiry on the same edge: the press wins (CAPTURED, timeout stays 0).
REQ-023 ack in ARMED cancels the round: FSM goes to IDLE, no capture, rr_ptr unchanged; ack takes priority over a simultaneous press or expiry.
REQ-024 In CAPTURED, the outputs hold and further presses are ignored; ack moves the FSM to IDLE and clears playerInputFlag and firstPlayerFlag to 0 on the same edge.
REQ-025 In TIMEOUT, presses are ignored; ack moves the FSM to IDLE and clears timeout.
REQ-026 arm in any state other than IDLE SHALL be ignored; arm and ack asserted together in IDLE yields ARMED.
REQ-027 Debounce logic SHALL run in every state, so a button held across arm never produces an event.

Reset
REQ-028 rst=0 SHALL asynchronously force:
- state=IDLE; playerInputFlag=0, firstPlayerFlag=0, timeout=0;
- rr_ptr=0; all synchronizer flops, debounced levels, edge registers and counters to 0.
REQ-029 Reset asserted mid-round SHALL discard the round; after release, the block stays in IDLE until a new arm.

Verification
REQ-030 With DEBOUNCE_CYCLES=4: arm, then btn=0010 held -> playerInputFlag=1, firstPlayerFlag=1, exactly 7 edges after btn first sampled; ack -> IDLE with flags 0.
REQ-031 With rr_ptr=0: arm, then btn=1010 rising on the same cycle -> winner 1; ack, arm, repeat btn=1010 -> winner 3 (rr_ptr=2); a third round -> winner 1.
REQ-032 lock=0100: arm, press player 2 only -> no capture; then press player 0 -> winner 0; a 2-cycle glitch on btn[3] never sets an event.
REQ-033 With TIMEOUT_CYCLES=10: arm, no presses -> state=3 and timeout=1 on the 10th edge after ARMED entry; a press arriving exactly on that edge -> CAPTURED instead, timeout=0.
REQ-034 btn[0] held high before arm -> no capture in ARMED; ack in ARMED -> IDLE with rr_ptr unchanged; rst=0 pulsed while in CAPTURED -> all outputs 0 immediately, without a clock edge.
